// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH+2 cycles from accepted start to done.
// Define DIV_SIGNED_EN for two's-complement operands; without it operands are unsigned.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // partial remainder (magnitude)
    logic [WIDTH-1:0] qsh_q, qsh_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH:0]   dvs_q, dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] dvd_q, dvd_d;      // raw dividend, returned as remainder on divide-by-zero
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dvr_neg;
    logic [WIDTH:0]   dvd_mag, dvr_mag;
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_qsh;

    // Magnitudes are formed in WIDTH+1 bits so the most-negative operand does not overflow.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_neg = dvd[WIDTH-1];
        dvr_neg = dvr[WIDTH-1];
`else
        dvd_neg = 1'b0;
        dvr_neg = 1'b0;
`endif
        dvd_mag = dvd_neg ? -{dvd[WIDTH-1], dvd} : {1'b0, dvd};
        dvr_mag = dvr_neg ? -{dvr[WIDTH-1], dvr} : {1'b0, dvr};
    end

    // One restoring step: shift, trial-subtract, keep or restore.
    always_comb begin
        shifted  = {acc_q, qsh_q[WIDTH-1]};
        trial_ok = (shifted >= dvs_q);
        step_acc = trial_ok ? WIDTH'(shifted - dvs_q) : shifted[WIDTH-1:0];
        step_qsh = {qsh_q[WIDTH-2:0], trial_ok};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is not taken.
                if (start && !done_q) begin
                    state_d = StIter;
                    cnt_d   = '0;
                    acc_d   = '0;
                    qsh_d   = WIDTH'(dvd_mag);
                    dvs_d   = dvr_mag;
                    dvd_d   = dvd;
                    negq_d  = dvd_neg ^ dvr_neg;
                    negr_d  = dvd_neg;
                    zero_d  = (dvr == '0);
                    busy_d  = 1'b1;
                end
            end
            StIter: begin
                acc_d = step_acc;
                qsh_d = step_qsh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zero_q) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = negq_q ? -qsh_q : qsh_q;
                    rem_d = negr_q ? -acc_q : acc_q;
                    dbz_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            qsh_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Table-driven bench for seq_divider (WIDTH=4); vectors follow DIV_SIGNED_EN when defined.
module tb_seq_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dvd;
    logic [3:0] dvr;
    logic       busy;
    logic       done;
    logic [3:0] quo;
    logic [3:0] rem;
    logic       dbz;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .dvd  (dvd),
        .dvr  (dvr),
        .busy (busy),
        .done (done),
        .quo  (quo),
        .rem  (rem),
        .dbz  (dbz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one division and watch latency, busy span, pulse count and results.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                          input logic [3:0] er, input logic ez, input string tag);
        int         lat    = -1;
        int         busy_n = 0;
        int         pulses = 0;
        logic [3:0] cq     = '0;
        logic [3:0] cr     = '0;
        logic       cz     = 1'b0;
        @(negedge clock);
        dvd   = a;
        dvr   = b;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cq  = quo;
                    cr  = rem;
                    cz  = dbz;
                end
            end
            if (busy) busy_n++;
            if (k == 1) start = 1'b0;
        end
        check({tag, ".latency"}, lat, 6);
        check({tag, ".busy_cycles"}, busy_n, 5);
        check({tag, ".done_pulses"}, pulses, 1);
        check({tag, ".quo"}, int'(cq), int'(eq));
        check({tag, ".rem"}, int'(cr), int'(er));
        check({tag, ".dbz"}, int'(cz), int'(ez));
        check({tag, ".quo_hold"}, int'(quo), int'(eq));
    endtask

    initial begin
`ifdef DIV_SIGNED_EN
        tbl[0] = '{a: 4'd7,    b: 4'd2,    q: 4'd3,    r: 4'd1,    z: 1'b0};
        tbl[1] = '{a: 4'b1001, b: 4'd2,    q: 4'b1101, r: 4'b1111, z: 1'b0};
        tbl[2] = '{a: 4'b1000, b: 4'b1111, q: 4'b1000, r: 4'd0,    z: 1'b0};
        tbl[3] = '{a: 4'd7,    b: 4'b1110, q: 4'b1101, r: 4'd1,    z: 1'b0};
        tbl[4] = '{a: 4'b1010, b: 4'b1101, q: 4'd2,    r: 4'd0,    z: 1'b0};
        tbl[5] = '{a: 4'd5,    b: 4'd0,    q: 4'b1111, r: 4'b0101, z: 1'b1};
        tbl[6] = '{a: 4'b1000, b: 4'd0,    q: 4'b1111, r: 4'b1000, z: 1'b1};
        tbl[7] = '{a: 4'b1111, b: 4'd4,    q: 4'd0,    r: 4'b1111, z: 1'b0};
`else
        tbl[0] = '{a: 4'd7,    b: 4'd2,    q: 4'd3,    r: 4'd1,    z: 1'b0};
        tbl[1] = '{a: 4'b1001, b: 4'd2,    q: 4'd4,    r: 4'd1,    z: 1'b0};
        tbl[2] = '{a: 4'd5,    b: 4'd0,    q: 4'b1111, r: 4'b0101, z: 1'b1};
        tbl[3] = '{a: 4'd15,   b: 4'd1,    q: 4'd15,   r: 4'd0,    z: 1'b0};
        tbl[4] = '{a: 4'd0,    b: 4'd3,    q: 4'd0,    r: 4'd0,    z: 1'b0};
        tbl[5] = '{a: 4'd15,   b: 4'd15,   q: 4'd1,    r: 4'd0,    z: 1'b0};
        tbl[6] = '{a: 4'd3,    b: 4'd7,    q: 4'd0,    r: 4'd3,    z: 1'b0};
        tbl[7] = '{a: 4'd14,   b: 4'd3,    q: 4'd4,    r: 4'd2,    z: 1'b0};
`endif

        reset = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvr   = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.quo", int'(quo), 0);
        check("reset.rem", int'(rem), 0);
        check("reset.dbz", int'(dbz), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("vec%0d", i));
        end

        // Re-asserted start while busy is ignored; start held into the done cycle is not taken.
        begin
            int         pulses = 0;
            int         lat    = -1;
            logic [3:0] cq     = '0;
            logic [3:0] cr     = '0;
            @(negedge clock);
            dvd   = 4'd6;
            dvr   = 4'd3;
            start = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clock);
                if (done) begin
                    pulses++;
                    if (lat < 0) begin
                        lat = k;
                        cq  = quo;
                        cr  = rem;
                    end
                end
                if (k == 1) start = 1'b0;
                if (k == 2) begin
                    start = 1'b1;
                    dvd   = 4'd15;
                    dvr   = 4'd1;
                end
                if (k == 7) begin
                    check("restart.no_accept_in_done_cycle", int'(busy), 0);
                    start = 1'b0;
                end
            end
            check("restart.latency", lat, 6);
            check("restart.done_pulses", pulses, 1);
            check("restart.quo", int'(cq), 2);
            check("restart.rem", int'(cr), 0);
        end

        // Reset on the third ITER cycle aborts with no done pulse.
        begin
            int pulses = 0;
            @(negedge clock);
            dvd   = 4'd7;
            dvr   = 4'd2;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            @(negedge clock);
            @(negedge clock);
            check("abort.busy_before", int'(busy), 1);
            reset = 1'b1;
            @(negedge clock);
            check("abort.busy", int'(busy), 0);
            check("abort.done", int'(done), 0);
            check("abort.quo", int'(quo), 0);
            check("abort.rem", int'(rem), 0);
            check("abort.dbz", int'(dbz), 0);
            reset = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clock);
                if (done) pulses++;
            end
            check("abort.no_done", pulses, 0);
            run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "after_abort");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result bit width (WIDTH >= 2).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dvd  input  WIDTH  dividend; sampled with start.
REQ-006 SHALL have port dvr  input  WIDTH  divisor; sampled with start.
REQ-007 SHALL have port busy  output  1  high from the accept edge until the edge that raises done.
REQ-008 SHALL have port done  output  1  one-cycle pulse; quo/rem/dbz valid.
REQ-009 SHALL have port quo  output  WIDTH  quotient, registered.
REQ-010 SHALL have port rem  output  WIDTH  remainder, registered.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag, registered, valid with done.

Function
REQ-012 SHALL implement an FSM with states IDLE, ITER, FIX.
REQ-013 IDLE with start=1 SHALL latch dvd/dvr (magnitudes when signed), clear the partial remainder, clear the iteration counter, set busy, and go to ITER.
REQ-014 Each ITER cycle SHALL perform one restoring step: shift {remainder, quotient} left 1, trial-subtract the divisor, keep the result and set the quotient LSB if non-negative, otherwise restore.
REQ-015 The FSM SHALL stay in ITER for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction, write quo/rem/dbz, pulse done, clear busy, and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle exactly WIDTH+2 cycles after the cycle in which start was sampled high.
REQ-018 quo/rem/dbz SHALL hold their values until the next FIX or reset.
REQ-019 start while busy SHALL be ignored with no effect on the operation in progress; back-to-back start in the done cycle SHALL not be accepted (FSM is in IDLE the following cycle).
REQ-020 A divisor of zero SHALL produce quo = all ones, rem = dvd, dbz = 1, with the normal latency.
REQ-021 Signed mode: quotient SHALL truncate toward zero; rem SHALL take the dividend's sign; quo*dvr+rem SHALL equal dvd modulo 2^WIDTH.
REQ-022 Signed most-negative / -1 SHALL yield quo = most-negative value (wrap) and rem = 0, with dbz = 0.
REQ-023 Internal magnitude arithmetic SHALL use WIDTH+1 bits so that a most-negative operand magnitude does not overflow.

Reset
REQ-024 reset=1 SHALL force IDLE and busy=0, done=0, quo=0, rem=0, dbz=0, counter=0 at the next edge.
REQ-025 reset asserted mid-operation SHALL abort without a done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-026 With macro DIV_SIGNED_EN defined, operands SHALL be two's-complement and REQ-021/REQ-022 SHALL apply.
REQ-027 Without DIV_SIGNED_EN, operands SHALL be unsigned, FIX SHALL perform no sign correction, and latency SHALL be unchanged.

Verification (WIDTH=4)
REQ-028 dvd=7, dvr=2, start 1 cycle -> done exactly 6 cycles later; quo=3, rem=1, dbz=0; busy high for 5 cycles.
REQ-029 DIV_SIGNED_EN: dvd=4'b1001 (-7), dvr=2 -> quo=4'b1101 (-3), rem=4'b1111 (-1); DIV_SIGNED_EN, dvd=4'b1000, dvr=4'b1111 -> quo=4'b1000, rem=0.
REQ-030 dvd=5, dvr=0 -> quo=4'b1111, rem=4'b0101, dbz=1, same latency.
REQ-031 No macro: dvd=4'b1001 (9), dvr=2 -> quo=4, rem=1.
REQ-032 start with dvd=6, dvr=3, then start re-asserted with dvd=15, dvr=1 two cycles later -> single done with quo=2, rem=0.
REQ-033 reset asserted on the 3rd ITER cycle -> no done pulse; all outputs 0 next cycle; a fresh start then completes normally.
